alu_cmd_sequencer: RTL



---
 rtl/alu_cmd_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 4-bit ALU: accepts one command, reads two
// operands from a 4x4 register file, and writes the ALU result back.
module alu_cmd_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs1,
    input  logic [1:0] cmd_rs2,
    input  logic [3:0] cmd_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_zero,
    output logic       rsp_valid,
    output logic [3:0] rsp_result,
    output logic       rsp_zero,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] OP_LDI = 3'b111;

    state_e     state_q;
    logic [3:0] rf_q [4];
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] op_q;
    logic [1:0] rd_q;
    logic [3:0] imm_q;
    logic       rdy_q;
    logic       vld_q;
    logic [3:0] res_q;
    logic       zero_q;

    logic [3:0] wr_d;
    logic       wz_d;

    // Load-immediate bypasses the ALU entirely.
    always_comb begin
        wr_d = alu_result;
        wz_d = alu_zero;
        if (op_q == OP_LDI) begin
            wr_d = imm_q;
            wz_d = (imm_q == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= 4'd0;
            end
            a_q    <= 4'd0;
            b_q    <= 4'd0;
            op_q   <= 3'd0;
            rd_q   <= 2'd0;
            imm_q  <= 4'd0;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            res_q  <= 4'd0;
            zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        a_q     <= rf_q[cmd_rs1];
                        b_q     <= rf_q[cmd_rs2];
                        op_q    <= cmd_op;
                        rd_q    <= cmd_rd;
                        imm_q   <= cmd_imm;
                        rdy_q   <= 1'b0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rf_q[rd_q] <= wr_d;
                    res_q      <= wr_d;
                    zero_q     <= wz_d;
                    vld_q      <= 1'b1;
                    state_q    <= RESP;
                end
                RESP: begin
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = rdy_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_valid  = vld_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign dbg_data   = rf_q[dbg_addr];

endmodule
